// File: rtl/ps2_key_encoder_pkg.sv
// rtl/ps2_key_encoder_pkg.sv - shared types and constants for the PS/2 set-2 key encoder
package ps2_key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GOT_E0   = 3'd1,
    ST_GOT_F0   = 3'd2,
    ST_GOT_E0F0 = 3'd3
`ifdef PS2_PAUSE_EN
    ,
    ST_PAUSE    = 3'd4
`endif
  } ps2_state_t;

  localparam logic [7:0] PS2_PFX_EXT     = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK     = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE   = 8'hE1;
  localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

  localparam int KEY_TOGGLE_BIT  = 10;
  localparam int KEY_PRESSED_BIT = 9;
  localparam int KEY_EXT_BIT     = 8;
  localparam int KEY_CODE_MSB    = 7;
  localparam int KEY_CODE_LSB    = 0;

  // Bytes that follow the leading E1 of Pause; entry 0 is the first expected byte.
  localparam int          PS2_PAUSE_LEN = 7;
  localparam logic [6:0][7:0] PS2_PAUSE_SEQ = {
    8'h77, 8'hF0, 8'h14, 8'hF0, 8'hE1, 8'h77, 8'h14
  };

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == PS2_FAKE_LSHIFT) || (b == PS2_FAKE_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_key_encoder_if.sv
// rtl/ps2_key_encoder_if.sv - scancode input and key event output bundle
interface ps2_key_encoder_if;

  logic        scan_valid;
  logic [7:0]  scan_byte;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        seq_err;

  modport master (
    output scan_valid,
    output scan_byte,
    input  ps2_key,
    input  key_strobe,
    input  seq_err
  );

  modport slave (
    input  scan_valid,
    input  scan_byte,
    output ps2_key,
    output key_strobe,
    output seq_err
  );

endinterface

// File: rtl/ps2_key_encoder_seq_timer.sv
// rtl/ps2_key_encoder_seq_timer.sv - saturating idle counter for stalled prefix sequences
module ps2_seq_timer #(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Holds at the last value instead of wrapping so a stall can never re-arm silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && (cnt != CNT_LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = run && (cnt == CNT_LAST);

endmodule

// File: rtl/ps2_key_encoder.sv
// rtl/ps2_key_encoder.sv - PS/2 set-2 byte stream to toggle-format key events; PS2_PAUSE_EN enables Pause decoding
module ps2_key_encoder
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic              clk_25,
  input  logic              reset,
  ps2_key_encoder_if.slave  bus
);

  ps2_state_t state_q;
  ps2_state_t state_d;
  logic       emit;
  logic       emit_pressed;
  logic       emit_ext;
  logic       err;
  logic       expire;
  logic [7:0] byte_in;

`ifdef PS2_PAUSE_EN
  logic [2:0] idx_q;
  logic [2:0] idx_d;
`endif

  assign byte_in = bus.scan_byte;

  ps2_seq_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk_25),
    .rst    (reset),
    .clear  (bus.scan_valid | expire),
    .run    (state_q != ST_IDLE),
    .expire (expire)
  );

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
`ifdef PS2_PAUSE_EN
      idx_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef PS2_PAUSE_EN
      idx_q   <= idx_d;
`endif
    end
  end

  // A byte arriving in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_d      = state_q;
    emit         = 1'b0;
    emit_pressed = 1'b0;
    emit_ext     = 1'b0;
    err          = 1'b0;
`ifdef PS2_PAUSE_EN
    idx_d        = idx_q;
`endif
    if (bus.scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_in == PS2_PFX_EXT) begin
            state_d = ST_GOT_E0;
          end else if (byte_in == PS2_PFX_BRK) begin
            state_d = ST_GOT_F0;
          end else if (byte_in == PS2_PFX_PAUSE) begin
`ifdef PS2_PAUSE_EN
            state_d = ST_PAUSE;
            idx_d   = 3'd0;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            emit         = 1'b1;
            emit_pressed = 1'b1;
          end
        end
        ST_GOT_E0: begin
          if (byte_in == PS2_PFX_BRK) begin
            state_d = ST_GOT_E0F0;
          end else if (byte_in == PS2_PFX_EXT) begin
            state_d = ST_GOT_E0;
          end else if (is_fake_shift(byte_in) || (byte_in == PS2_PFX_PAUSE)) begin
            state_d = ST_IDLE;
          end else begin
            emit         = 1'b1;
            emit_pressed = 1'b1;
            emit_ext     = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          if (byte_in == PS2_PFX_BRK) begin
            state_d = ST_GOT_F0;
          end else if (byte_in == PS2_PFX_EXT) begin
            err     = 1'b1;
            state_d = ST_GOT_E0;
          end else if (byte_in == PS2_PFX_PAUSE) begin
            state_d = ST_IDLE;
          end else begin
            emit    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_GOT_E0F0: begin
          if (is_fake_shift(byte_in) || (byte_in == PS2_PFX_PAUSE)) begin
            state_d = ST_IDLE;
          end else if ((byte_in == PS2_PFX_EXT) || (byte_in == PS2_PFX_BRK)) begin
            err     = 1'b1;
            state_d = ST_IDLE;
          end else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = ST_IDLE;
          end
        end
`ifdef PS2_PAUSE_EN
        ST_PAUSE: begin
          if (byte_in != PS2_PAUSE_SEQ[idx_q]) begin
            err     = 1'b1;
            state_d = ST_IDLE;
          end else if (idx_q == 3'(PS2_PAUSE_LEN - 1)) begin
            emit         = 1'b1;
            emit_pressed = 1'b1;
            emit_ext     = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (expire) begin
      err     = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      bus.ps2_key    <= 11'h000;
      bus.key_strobe <= 1'b0;
      bus.seq_err    <= 1'b0;
    end else begin
      bus.key_strobe <= emit;
      bus.seq_err    <= err;
      if (emit) begin
        bus.ps2_key[KEY_TOGGLE_BIT]             <= ~bus.ps2_key[KEY_TOGGLE_BIT];
        bus.ps2_key[KEY_PRESSED_BIT]            <= emit_pressed;
        bus.ps2_key[KEY_EXT_BIT]                <= emit_ext;
        bus.ps2_key[KEY_CODE_MSB:KEY_CODE_LSB]  <= byte_in;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb/tb_ps2_key_encoder.sv - scoreboard bench for ps2_key_encoder
module tb_ps2_key_encoder;

  localparam int TO = 16;

  typedef struct packed {
    logic        is_err;
    logic [10:0] key;
  } exp_t;

  logic clk_25;
  logic reset;
  logic toggle;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  ps2_key_encoder_if bus ();

  ps2_key_encoder #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_25 (clk_25),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  // Every strobe or error pulse must match the oldest queued expectation.
  always @(negedge clk_25) begin
    if (!reset && (bus.key_strobe || bus.seq_err)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse strobe=%0b err=%0b key=%h required none",
                 bus.key_strobe, bus.seq_err, bus.ps2_key);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_err) begin
          if (!(bus.seq_err && !bus.key_strobe)) begin
            errors++;
            $display("FAIL seq_err_pulse strobe=%0b err=%0b required strobe=0 err=1",
                     bus.key_strobe, bus.seq_err);
          end
        end else if (!(bus.key_strobe && !bus.seq_err) || (bus.ps2_key !== e.key)) begin
          errors++;
          $display("FAIL key_event strobe=%0b err=%0b key=%h required strobe=1 err=0 key=%h",
                   bus.key_strobe, bus.seq_err, bus.ps2_key, e.key);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_25);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.scan_valid = 1'b1;
    bus.scan_byte  = b;
    @(posedge clk_25);
    #1;
    bus.scan_valid = 1'b0;
    bus.scan_byte  = 8'h00;
  endtask

  task automatic exp_evt(input logic pressed, input logic ext, input logic [7:0] code);
    exp_t e;
    toggle   = ~toggle;
    e.is_err = 1'b0;
    e.key    = {toggle, pressed, ext, code};
    exp_q.push_back(e);
  endtask

  task automatic exp_err();
    exp_t e;
    e.is_err = 1'b1;
    e.key    = 11'h000;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ((bus.ps2_key !== 11'h000) || (bus.key_strobe !== 1'b0) || (bus.seq_err !== 1'b0)) begin
      errors++;
      $display("FAIL %s key=%h strobe=%0b err=%0b required key=000 strobe=0 err=0",
               name, bus.ps2_key, bus.key_strobe, bus.seq_err);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    toggle = 1'b0;
    reset  = 1'b1;
    bus.scan_valid = 1'b0;
    bus.scan_byte  = 8'h00;
    idle(3);
    reset = 1'b0;
    idle(1);
    check_reset_outputs("reset_state");

    exp_evt(1'b1, 1'b0, 8'h1C); send(8'h1C);
    send(8'hF0); exp_evt(1'b0, 1'b0, 8'h1C); send(8'h1C);
    idle(2);

    send(8'hE0); exp_evt(1'b1, 1'b1, 8'h6B); send(8'h6B);
    send(8'hE0); send(8'hF0); exp_evt(1'b0, 1'b1, 8'h6B); send(8'h6B);
    idle(2);

    send(8'hE0); send(8'h12); send(8'hE0); exp_evt(1'b1, 1'b1, 8'h7C); send(8'h7C);
    send(8'hE0); send(8'hF0); send(8'h59);
    send(8'hE0); send(8'hE0); exp_evt(1'b1, 1'b1, 8'h74); send(8'h74);
    send(8'hF0); send(8'hF0); exp_evt(1'b0, 1'b0, 8'h2A); send(8'h2A);
    idle(2);

    send(8'hF0); exp_err(); send(8'hE0); exp_evt(1'b1, 1'b1, 8'h75); send(8'h75);
    send(8'hE0); send(8'hF0); exp_err(); send(8'hF0);
    exp_evt(1'b1, 1'b0, 8'h2A); send(8'h2A);
    exp_evt(1'b1, 1'b0, 8'h2A); send(8'h2A);
    idle(2);

    send(8'hE0); exp_err(); idle(TO + 2);
    exp_evt(1'b1, 1'b0, 8'h1C); send(8'h1C);
    idle(2);

    send(8'hE0); idle(TO - 1); exp_evt(1'b1, 1'b1, 8'h23); send(8'h23);
    idle(TO + 2);

`ifdef PS2_PAUSE_EN
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    exp_evt(1'b1, 1'b1, 8'h77); send(8'h77);
    idle(2);
    send(8'hE1); exp_err(); send(8'h15);
    exp_evt(1'b1, 1'b0, 8'h1C); send(8'h1C);
`else
    send(8'hE1); exp_evt(1'b1, 1'b0, 8'h1C); send(8'h1C);
    send(8'hE0); send(8'hE1); exp_evt(1'b1, 1'b0, 8'h74); send(8'h74);
`endif
    idle(2);

    send(8'hE0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    toggle = 1'b0;
    idle(1);
    check_reset_outputs("midseq_reset");
    exp_evt(1'b1, 1'b0, 8'h1C); send(8'h1C);
    idle(TO + 4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events pending=%0d required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
